uart_cmd_exec: RTL and testbench

UART command executor for the DDS control path. It takes each received UART byte, holds it in a one-deep buffer, and presents it with the current mode to the combinational acknowledge checker. It then samples the returned ACK byte, writes the DDS configuration register selected by the command only when the ACK is accepting, and sends the ACK byte back through the UART transmitter with a start/busy handshake.

---
 rtl/uart_cmd_exec.sv | 204 ++++++++++++++++++++
 tb/tb_uart_cmd_exec.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_exec.sv
// rtl/uart_cmd_exec.sv - UART command executor driving DDS configuration registers
//
// Takes each received byte and presents it, with the current mode, to an external
// combinational ACK checker. Writes the selected DDS register when the ACK is 8'h01,
// then returns the ACK byte through the UART transmitter using a start/busy handshake.
//
// Optional feature macro: CMD_ECHO_EN (when defined, the command byte is also sent
// back after the ACK byte).
//
// Parameters:
//   ERR_W            width of the saturating reject counter
// Ports:
//   clk_in           system clock
//   rst_in           synchronous active-high reset
//   rx_data_in       received byte, valid with rx_valid_in
//   rx_valid_in      one-cycle strobe per received byte
//   cmd_byte_out     latched command byte (to checker data input)
//   ack_in           checker result, 8'h01 = accept
//   tx_data_out      byte to transmit
//   tx_start_out     one-cycle transmit request
//   tx_busy_in       transmitter busy
//   freq_coarse_out  cmd 000, 5-bit value
//   freq_fine_out    cmd 001, 5-bit value
//   amp_out          cmd 010, 5-bit value
//   phase_out        cmd 011, 5-bit value
//   duty_out         cmd 100, 5-bit value
//   wave_sel_out     cmd 101, 4-bit value
//   mode_out         cmd 110, 4-bit one-hot mode (to checker mode input)
//   chan_en_out      cmd 111, 4-bit one-hot channel enable
//   update_out       one-cycle pulse per accepted write
//   err_cnt_out      saturating count of rejected commands
//   overrun_out      sticky, set when a received byte is dropped

`timescale 1ns/1ps

module uart_cmd_exec #(
  parameter int ERR_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [7:0]       rx_data_in,
  input  logic             rx_valid_in,
  output logic [7:0]       cmd_byte_out,
  input  logic [7:0]       ack_in,
  output logic [7:0]       tx_data_out,
  output logic             tx_start_out,
  input  logic             tx_busy_in,
  output logic [4:0]       freq_coarse_out,
  output logic [4:0]       freq_fine_out,
  output logic [4:0]       amp_out,
  output logic [4:0]       phase_out,
  output logic [4:0]       duty_out,
  output logic [3:0]       wave_sel_out,
  output logic [3:0]       mode_out,
  output logic [3:0]       chan_en_out,
  output logic             update_out,
  output logic [ERR_W-1:0] err_cnt_out,
  output logic             overrun_out
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SEND,
    TXW,
    TXD
`ifdef CMD_ECHO_EN
    , ECHO
`endif
  } state_t;

  localparam logic [7:0] ACK_OK = 8'h01;

  state_t     state;
  logic [7:0] pend_data;
  logic       pend_valid;
`ifdef CMD_ECHO_EN
  logic       echo_phase;   // set while the second (echo) byte is in flight
`endif

  // The pending byte is consumed in IDLE ahead of any new arrival.
  logic pend_take;
  // A fresh byte is taken straight into cmd_byte_out only when IDLE has nothing pending.
  logic rx_take;

  always_comb begin
    pend_take = (state == IDLE) && pend_valid;
    rx_take   = (state == IDLE) && !pend_valid && rx_valid_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      pend_data       <= 8'h00;
      pend_valid      <= 1'b0;
      cmd_byte_out    <= 8'h00;
      tx_data_out     <= 8'hFF;
      tx_start_out    <= 1'b0;
      freq_coarse_out <= 5'h00;
      freq_fine_out   <= 5'h00;
      amp_out         <= 5'h00;
      phase_out       <= 5'h00;
      duty_out        <= 5'h00;
      wave_sel_out    <= 4'h0;
      mode_out        <= 4'b0001;
      chan_en_out     <= 4'h0;
      update_out      <= 1'b0;
      err_cnt_out     <= '0;
      overrun_out     <= 1'b0;
`ifdef CMD_ECHO_EN
      echo_phase      <= 1'b0;
`endif
    end else begin
      tx_start_out <= 1'b0;
      update_out   <= 1'b0;

      // One-deep pending buffer. A slot freed by IDLE this cycle may be refilled
      // by a byte arriving in the same cycle; otherwise a full slot drops the new byte.
      if (pend_take) begin
        pend_valid <= 1'b0;
      end
      if (rx_valid_in && !rx_take) begin
        if (pend_valid && !pend_take) begin
          overrun_out <= 1'b1;
        end else begin
          pend_data  <= rx_data_in;
          pend_valid <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (pend_valid) begin
            cmd_byte_out <= pend_data;
            state        <= CHECK;
          end else if (rx_valid_in) begin
            cmd_byte_out <= rx_data_in;
            state        <= CHECK;
          end
        end

        CHECK: begin
          if (ack_in == ACK_OK) begin
            update_out <= 1'b1;
            case (cmd_byte_out[7:5])
              3'b000:  freq_coarse_out <= cmd_byte_out[4:0];
              3'b001:  freq_fine_out   <= cmd_byte_out[4:0];
              3'b010:  amp_out         <= cmd_byte_out[4:0];
              3'b011:  phase_out       <= cmd_byte_out[4:0];
              3'b100:  duty_out        <= cmd_byte_out[4:0];
              3'b101:  wave_sel_out    <= cmd_byte_out[3:0];
              3'b110:  mode_out        <= cmd_byte_out[3:0];
              default: chan_en_out     <= cmd_byte_out[3:0];
            endcase
          end else if (err_cnt_out != {ERR_W{1'b1}}) begin
            err_cnt_out <= err_cnt_out + ERR_W'(1);
          end
          tx_data_out <= ack_in;
          state       <= SEND;
        end

        SEND: begin
          if (!tx_busy_in) begin
            tx_start_out <= 1'b1;
            state        <= TXW;
          end
        end

        TXW: begin
          // Wait for the transmitter to acknowledge the start request.
          if (tx_busy_in) begin
            state <= TXD;
          end
        end

        TXD: begin
          if (!tx_busy_in) begin
`ifdef CMD_ECHO_EN
            if (echo_phase) begin
              echo_phase <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= ECHO;
            end
`else
            state <= IDLE;
`endif
          end
        end

`ifdef CMD_ECHO_EN
        ECHO: begin
          tx_data_out <= cmd_byte_out;
          echo_phase  <= 1'b1;
          state       <= SEND;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_exec.sv
// tb/tb_uart_cmd_exec.sv - directed table-driven bench for uart_cmd_exec

`timescale 1ns/1ps

module tb_uart_cmd_exec;

`ifdef CMD_ECHO_EN
  localparam int TX_PER = 2;
`else
  localparam int TX_PER = 1;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] cmd_byte;
  logic [7:0] ack_in;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] freq_coarse, freq_fine, amp, phase, duty;
  logic [3:0] wave_sel, mode, chan_en;
  logic       update;
  logic [1:0] err_cnt;
  logic       overrun;

  logic       model_busy;
  logic       force_busy;
  logic       use_model;
  logic [7:0] ack_drv;
  logic [7:0] model_ack;

  int         checks;
  int         failures;
  int         upd_count;
  logic [7:0] tx_log[$];

  uart_cmd_exec #(.ERR_W(2)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .rx_data_in      (rx_data),
    .rx_valid_in     (rx_valid),
    .cmd_byte_out    (cmd_byte),
    .ack_in          (ack_in),
    .tx_data_out     (tx_data),
    .tx_start_out    (tx_start),
    .tx_busy_in      (tx_busy),
    .freq_coarse_out (freq_coarse),
    .freq_fine_out   (freq_fine),
    .amp_out         (amp),
    .phase_out       (phase),
    .duty_out        (duty),
    .wave_sel_out    (wave_sel),
    .mode_out        (mode),
    .chan_en_out     (chan_en),
    .update_out      (update),
    .err_cnt_out     (err_cnt),
    .overrun_out     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in checker: rejects waveform commands unless mode is 4'b0010.
  assign model_ack = (cmd_byte[7:5] == 3'b101 && mode != 4'b0010) ? 8'hFF : 8'h01;
  assign ack_in    = use_model ? model_ack : ack_drv;
  assign tx_busy   = model_busy | force_busy;

  // Transmitter model: log each started byte, then stay busy for a few cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_log.push_back(tx_data);
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  initial begin
    upd_count = 0;
    forever begin
      @(negedge clk);
      if (update) upd_count++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] regs_now();
    return 64'({freq_coarse, freq_fine, amp, phase, duty, wave_sel, mode, chan_en});
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_byte"}, 64'(cmd_byte), 64'h00);
    chk({tag, "_tx_data"},  64'(tx_data),  64'hFF);
    chk({tag, "_tx_start"}, 64'(tx_start), 64'h0);
    chk({tag, "_regs"},     regs_now(),    64'({5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 4'h0, 4'b0001, 4'h0}));
    chk({tag, "_update"},   64'(update),   64'h0);
    chk({tag, "_err_cnt"},  64'(err_cnt),  64'h0);
    chk({tag, "_overrun"},  64'(overrun),  64'h0);
  endtask

  // Issue one command from IDLE and check the N+1 / N+2 / N+3 latencies.
  task automatic run_cmd(input string name, input logic [7:0] b, input logic [7:0] a,
                         input logic exp_upd, input logic [7:0] exp_tx);
    int base_tx;
    int base_upd;
    base_tx  = tx_log.size();
    base_upd = upd_count;
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    ack_drv  = a;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    chk({name, "_cmd_byte"}, 64'(cmd_byte), 64'(b));
    @(negedge clk);
    chk({name, "_update"},  64'(update),  64'(exp_upd));
    chk({name, "_tx_data"}, 64'(tx_data), 64'(exp_tx));
    @(negedge clk);
    chk({name, "_tx_start"}, 64'(tx_start), 64'h1);
    repeat (30) @(posedge clk);
    chk({name, "_tx_count"}, 64'(tx_log.size() - base_tx), 64'(TX_PER));
    chk({name, "_upd_count"}, 64'(upd_count - base_upd), 64'(exp_upd));
    if (tx_log.size() > base_tx) begin
      chk({name, "_tx_byte"}, 64'(tx_log[base_tx]), 64'(exp_tx));
`ifdef CMD_ECHO_EN
      if (tx_log.size() > base_tx + 1) begin
        chk({name, "_echo_byte"}, 64'(tx_log[base_tx + 1]), 64'(b));
      end
`endif
    end
  endtask

  typedef struct {
    logic [7:0] rx;
    logic [7:0] ack;
    logic       upd;
    logic [7:0] tx;
    logic [4:0] fc, ff, am, ph, du;
    logic [3:0] wv, md, ch;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int base_tx;
    int base_upd;

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    ack_drv    = 8'h01;
    use_model  = 1'b0;
    force_busy = 1'b0;

    //            rx     ack    upd   tx     fc     ff     amp    ph     duty   wave  mode     chan  err
    vecs[0]  = '{8'h4A, 8'h01, 1'b1, 8'h01, 5'h00, 5'h00, 5'h0A, 5'h00, 5'h00, 4'h0, 4'b0001, 4'h0, 2'd0};
    vecs[1]  = '{8'h00, 8'hFF, 1'b0, 8'hFF, 5'h00, 5'h00, 5'h0A, 5'h00, 5'h00, 4'h0, 4'b0001, 4'h0, 2'd1};
    vecs[2]  = '{8'h1F, 8'h01, 1'b1, 8'h01, 5'h1F, 5'h00, 5'h0A, 5'h00, 5'h00, 4'h0, 4'b0001, 4'h0, 2'd1};
    vecs[3]  = '{8'h3E, 8'h01, 1'b1, 8'h01, 5'h1F, 5'h1E, 5'h0A, 5'h00, 5'h00, 4'h0, 4'b0001, 4'h0, 2'd1};
    vecs[4]  = '{8'h6D, 8'h01, 1'b1, 8'h01, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h00, 4'h0, 4'b0001, 4'h0, 2'd1};
    vecs[5]  = '{8'h91, 8'h01, 1'b1, 8'h01, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h11, 4'h0, 4'b0001, 4'h0, 2'd1};
    vecs[6]  = '{8'hB5, 8'h00, 1'b0, 8'h00, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h11, 4'h0, 4'b0001, 4'h0, 2'd2};
    vecs[7]  = '{8'hB5, 8'h01, 1'b1, 8'h01, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h11, 4'h5, 4'b0001, 4'h0, 2'd2};
    vecs[8]  = '{8'hC4, 8'h01, 1'b1, 8'h01, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h11, 4'h5, 4'b0100, 4'h0, 2'd2};
    vecs[9]  = '{8'hE8, 8'h01, 1'b1, 8'h01, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h11, 4'h5, 4'b0100, 4'h8, 2'd2};
    vecs[10] = '{8'h9F, 8'h02, 1'b0, 8'h02, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h11, 4'h5, 4'b0100, 4'h8, 2'd3};
    vecs[11] = '{8'hD1, 8'h01, 1'b1, 8'h01, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h11, 4'h5, 4'b0001, 4'h8, 2'd3};
    vecs[12] = '{8'h00, 8'h00, 1'b0, 8'h00, 5'h1F, 5'h1E, 5'h0A, 5'h0D, 5'h11, 4'h5, 4'b0001, 4'h8, 2'd3};

    do_reset();
    @(negedge clk);
    check_reset_vals("reset");

    for (int i = 0; i < 13; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      run_cmd(nm, vecs[i].rx, vecs[i].ack, vecs[i].upd, vecs[i].tx);
      chk({nm, "_regs"}, regs_now(),
          64'({vecs[i].fc, vecs[i].ff, vecs[i].am, vecs[i].ph, vecs[i].du,
               vecs[i].wv, vecs[i].md, vecs[i].ch}));
      chk({nm, "_err_cnt"}, 64'(err_cnt), 64'(vecs[i].err));
      chk({nm, "_overrun"}, 64'(overrun), 64'h0);
    end

    // Mode dependence: wave command rejected under mode 0001, accepted after mode 0010.
    do_reset();
    use_model = 1'b1;
    run_cmd("mode_wave_rej", 8'hA7, 8'h00, 1'b0, 8'hFF);
    chk("mode_wave_rej_wave", 64'(wave_sel), 64'h0);
    chk("mode_wave_rej_err",  64'(err_cnt),  64'h1);
    run_cmd("mode_set", 8'hC2, 8'h00, 1'b1, 8'h01);
    chk("mode_set_mode", 64'(mode), 64'h2);
    run_cmd("mode_wave_acc", 8'hA7, 8'h00, 1'b1, 8'h01);
    chk("mode_wave_acc_wave", 64'(wave_sel), 64'h7);
    use_model = 1'b0;

    // Buffering: three back-to-back bytes while the transmitter is held busy.
    do_reset();
    ack_drv    = 8'h01;
    force_busy = 1'b1;
    base_tx    = tx_log.size();
    base_upd   = upd_count;
    @(posedge clk);
    #1 rx_data = 8'h03; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_data = 8'h25;
    @(posedge clk);
    #1 rx_data = 8'h47;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    chk("buf_overrun_set",  64'(overrun),     64'h1);
    chk("buf_first_exec",   64'(freq_coarse), 64'h03);
    chk("buf_second_held",  64'(freq_fine),   64'h00);
    repeat (5) @(posedge clk);
    chk("buf_no_tx_while_busy", 64'(tx_log.size() - base_tx), 64'h0);
    #1 force_busy = 1'b0;
    repeat (70) @(posedge clk);
    chk("buf_second_exec",  64'(freq_fine),   64'h05);
    chk("buf_third_dropped", 64'(amp),        64'h00);
    chk("buf_tx_count",     64'(tx_log.size() - base_tx), 64'(2 * TX_PER));
    chk("buf_upd_count",    64'(upd_count - base_upd),    64'h2);
    chk("buf_overrun_sticky", 64'(overrun),   64'h1);

    // Reset while waiting in TXW: everything returns to reset values, no restart.
    do_reset();
    repeat (10) @(posedge clk);
    @(posedge clk);
    #1 rx_data = 8'h4A; rx_valid = 1'b1; ack_drv = 8'h01;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_start_seen", 64'(tx_start), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst      = 1'b0;
    base_tx  = tx_log.size();
    repeat (25) @(posedge clk);
    chk("rst_mid_no_restart", 64'(tx_log.size() - base_tx), 64'h0);
    chk("rst_mid_amp_clear",  64'(amp), 64'h0);

    // Echo behaviour (or plain single ACK byte without echo).
    run_cmd("echo_cmd", 8'h25, 8'h01, 1'b1, 8'h01);
    chk("echo_cmd_ff", 64'(freq_fine), 64'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
